miriscv_fetch_buffer: RTL

Instruction queue between the fetch unit and the decode stage. Captures each fetched {instr, pc, pc_next} triple, presents it to decode over a valid/ready handshake, and asserts early backpressure toward fetch. A control-unit redirect flushes it. It decouples the memory response from decode stalls, so fetch need not replay on every decode stall.

---
 rtl/miriscv_pkg.sv | 17 +
 rtl/miriscv_sync_fifo.sv | 72 +++++++
 rtl/miriscv_fetch_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/miriscv_pkg.sv
// Core-wide widths and shared types for the miriscv pipeline.
// Holds the fetch-buffer entry layout so decode can reuse it.
package miriscv_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned ILEN            = 32;
   localparam int unsigned FETCH_BUF_DEPTH = 4;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_next;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Generic synchronous FIFO: register storage, wrapping pointers, occupancy count.
// The caller qualifies push/pop; clear_i empties it on the next edge.
module miriscv_sync_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_next = count;
      if (clear_i) begin
         count_next = '0;
      end else if (push_i && !pop_i) begin
         count_next = count + CNT_W'(1);
      end else if (pop_i && !push_i) begin
         count_next = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) begin
         mem[wr_ptr] <= wdata_i;
      end
   end

   assign empty_o = (count == '0);
   assign full_o  = (count == CNT_W'(DEPTH));
   assign count_o = count;
   assign rdata_o = empty_o ? '0 : mem[rd_ptr];

   a_no_pop_empty : assert property (@(posedge clk_i) disable iff (arst_i)
      !(pop_i && empty_o && !clear_i));
   a_no_push_full : assert property (@(posedge clk_i) disable iff (arst_i)
      !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/miriscv_fetch_buffer.sv
// Fetch-to-decode instruction queue with early backpressure toward fetch,
// redirect flush and a dropped-push overflow indicator.
module miriscv_fetch_buffer
   import miriscv_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            fetch_rvalid_i,
   input  logic [ILEN-1:0] fetch_instr_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   input  logic [XLEN-1:0] fetch_pc_next_i,
   input  logic            flush_i,
   output logic            buf_stall_o,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output logic [ILEN-1:0] dec_instr_o,
   output logic [XLEN-1:0] dec_pc_o,
   output logic [XLEN-1:0] dec_pc_next_o,
   output logic            overflow_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     wr_entry;
   fetch_entry_t     rd_entry;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             drop;
   logic             stall_q;
   logic             overflow_q;

   always_comb begin
      wr_entry         = '0;
      wr_entry.instr   = fetch_instr_i;
      wr_entry.pc      = fetch_pc_i;
      wr_entry.pc_next = fetch_pc_next_i;
   end

   // Flush masks both sides; a full buffer only takes a push if it also pops.
   assign dec_valid_o = !fifo_empty && !flush_i;
   assign pop         = dec_valid_o && dec_ready_i;
   assign push        = fetch_rvalid_i && !flush_i && (!fifo_full || pop);
   assign drop        = fetch_rvalid_i && !flush_i && fifo_full && !pop;

   miriscv_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .clear_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (rd_entry),
      .count_o (count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      count_next = count;
      if (flush_i) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Stall one entry early so the response to an in-flight request still fits.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         stall_q    <= (count_next >= CNT_W'(DEPTH - 1));
         overflow_q <= drop;
      end
   end

   assign buf_stall_o   = stall_q;
   assign overflow_o    = overflow_q;
   assign dec_instr_o   = rd_entry.instr;
   assign dec_pc_o      = rd_entry.pc;
   assign dec_pc_next_o = rd_entry.pc_next;

endmodule
